// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo
//   Packet-mode AXI-Stream FIFO. By default, a packet is held until its tlast
//   beat has been written. Only then is it released downstream. If the FIFO
//   fills up while no complete packet is stored, that packet cannot ever be
//   completed in place. The FIFO then enters CUT_THROUGH, raises the sticky
//   oversize flag and streams the packet out as it arrives. It returns to
//   STORE when that packet's tlast beat leaves.
//
// Ports
//   aclk, areset          : single rising-edge clock, async active-high reset
//   s_axis_tdata/tstrb/tlast/tvalid, s_axis_tready : upstream slave stream
//   m_axis_tdata/tstrb/tlast/tvalid, m_axis_tready : downstream master stream
//   occupancy             : words currently stored (0..DEPTH)
//   pkt_count             : complete packets stored (excludes a cut-through packet)
//   oversize              : sticky, set when a packet exceeded DEPTH words
module axis_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic                      oversize
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  typedef enum logic {
    STORE       = 1'b0,
    CUT_THROUGH = 1'b1
  } state_t;

  // Storage is intentionally not reset; occupancy alone defines validity.
  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [SW-1:0]         strb_mem_r [DEPTH];
  logic                  last_mem_r [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state_r;
  logic          ct_last_seen_r;  // tlast of the cut-through packet has been written (uncounted)
  logic          ready_en_r;      // holds tready low until the first edge after reset release

  logic push_s;
  logic pop_s;
  logic pkt_inc_s;
  logic pkt_dec_s;

  // Handshakes are derived from registered state only, so s_axis_tready never
  // depends on m_axis_tready.
  assign s_axis_tready = ready_en_r && (occupancy != FULL_LVL);
  assign m_axis_tvalid = (occupancy != {CW{1'b0}}) &&
                         ((pkt_count != {CW{1'b0}}) || (state_r == CUT_THROUGH));

  assign push_s = s_axis_tvalid && s_axis_tready;
  assign pop_s  = m_axis_tvalid && m_axis_tready;

  // Head entry is presented straight from storage; it only changes on a pop.
  assign m_axis_tdata = data_mem_r[rd_ptr];
  assign m_axis_tstrb = strb_mem_r[rd_ptr];
  assign m_axis_tlast = last_mem_r[rd_ptr];

  // Packet counting: the cut-through packet's tlast is never counted, so its pop never decrements.
  always_comb begin
    pkt_inc_s = 1'b0;
    pkt_dec_s = 1'b0;
    if (state_r == CUT_THROUGH) begin
      pkt_inc_s = push_s && s_axis_tlast && ct_last_seen_r;
      pkt_dec_s = 1'b0;
    end else begin
      pkt_inc_s = push_s && s_axis_tlast;
      pkt_dec_s = pop_s && m_axis_tlast;
    end
  end

  // Storage write port.
  always_ff @(posedge aclk) begin
    if (push_s) begin
      data_mem_r[wr_ptr] <= s_axis_tdata;
      strb_mem_r[wr_ptr] <= s_axis_tstrb;
      last_mem_r[wr_ptr] <= s_axis_tlast;
    end
  end

  // Pointers, word occupancy and reset-release ready enable.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      occupancy  <= {CW{1'b0}};
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (push_s) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_s) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Complete-packet counter; a simultaneous counted write and pop cancel out.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_count <= {CW{1'b0}};
    end else begin
      case ({pkt_inc_s, pkt_dec_s})
        2'b10:   pkt_count <= pkt_count + CW'(1);
        2'b01:   pkt_count <= pkt_count - CW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // STORE / CUT_THROUGH state machine with the sticky oversize flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r        <= STORE;
      ct_last_seen_r <= 1'b0;
      oversize       <= 1'b0;
    end else begin
      case (state_r)
        STORE: begin
          // Full with no complete packet: the packet can never finish in place.
          if ((occupancy == FULL_LVL) && (pkt_count == {CW{1'b0}})) begin
            state_r        <= CUT_THROUGH;
            ct_last_seen_r <= 1'b0;
            oversize       <= 1'b1;
          end else begin
            state_r <= STORE;
          end
        end
        CUT_THROUGH: begin
          if (push_s && s_axis_tlast) begin
            ct_last_seen_r <= 1'b1;
          end
          // The first tlast leaving the FIFO is always the oversize packet's.
          if (pop_s && m_axis_tlast) begin
            state_r <= STORE;
          end else begin
            state_r <= CUT_THROUGH;
          end
        end
        default: begin
          state_r        <= STORE;
          ct_last_seen_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Randomized/directed bench for axis_pkt_fifo against a queue-based model.
// Model rules: words are a FIFO queue; pkt_count is the number of tlast words
// in the queue, minus the oversize packet's tlast while cutting through.
module tb_axis_pkt_fifo;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          aclk;
  logic          areset;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] pkt_count;
  logic          oversize;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .occupancy     (occupancy),
    .pkt_count     (pkt_count),
    .oversize      (oversize)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  beat_t q[$];
  bit    m_ct;
  bit    m_ovf;
  bit    m_rdy;
  int    checks;
  int    errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_last();
    int n = 0;
    foreach (q[i]) if (q[i].l) n++;
    return n;
  endfunction

  // One clock cycle: check outputs at the negedge, drive inputs, advance model.
  task automatic step(input logic sv, input logic [DW-1:0] d, input logic [SW-1:0] st,
                      input logic l, input logic mr, output bit pushed);
    int    nl;
    int    pc;
    bit    tv;
    bit    tr;
    bit    popped;
    beat_t b;
    nl = n_last();
    pc = nl - ((m_ct && nl > 0) ? 1 : 0);
    tr = m_rdy && (q.size() != DEPTH);
    tv = (q.size() != 0) && (m_ct || pc != 0);
    check_eq("occupancy", 64'(occupancy), 64'(q.size()));
    check_eq("pkt_count", 64'(pkt_count), 64'(pc));
    check_eq("oversize", 64'(oversize), 64'(m_ovf));
    check_eq("s_tready", 64'(s_axis_tready), 64'(tr));
    check_eq("m_tvalid", 64'(m_axis_tvalid), 64'(tv));
    if (tv) begin
      check_eq("m_tdata", 64'(m_axis_tdata), 64'(q[0].d));
      check_eq("m_tstrb", 64'(m_axis_tstrb), 64'(q[0].s));
      check_eq("m_tlast", 64'(m_axis_tlast), 64'(q[0].l));
    end
    s_axis_tvalid = sv;
    s_axis_tdata  = d;
    s_axis_tstrb  = st;
    s_axis_tlast  = l;
    m_axis_tready = mr;
    pushed = sv && tr;
    popped = tv && mr;
    if (!m_ct && q.size() == DEPTH && pc == 0) begin
      m_ct  = 1'b1;
      m_ovf = 1'b1;
    end else if (m_ct && popped && q[0].l) begin
      m_ct = 1'b0;
    end
    if (popped) void'(q.pop_front());
    if (pushed) begin
      b.d = d;
      b.s = st;
      b.l = l;
      q.push_back(b);
    end
    m_rdy = 1'b1;
    @(negedge aclk);
  endtask

  task automatic send_beats(input int n, input bit with_last, input int rdy_pct,
                            input int val_pct, input bit rand_data);
    int            sent = 0;
    int            guard = 0;
    bit            pushed;
    logic [DW-1:0] d;
    logic [SW-1:0] st;
    while (sent < n && guard < 2000) begin
      d  = rand_data ? DW'($urandom) : DW'(sent + 1);
      st = rand_data ? SW'($urandom) : {SW{1'b1}};
      step(($urandom_range(99) < val_pct), d, st, with_last && (sent == n - 1),
           ($urandom_range(99) < rdy_pct), pushed);
      if (pushed) sent++;
      guard++;
    end
    check_eq("send_done", 64'(sent), 64'(n));
  endtask

  task automatic drain(input int n, input int rdy_pct);
    bit pushed;
    for (int i = 0; i < n; i++) begin
      step(1'b0, {DW{1'b0}}, {SW{1'b0}}, 1'b0, ($urandom_range(99) < rdy_pct), pushed);
    end
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    areset = 1'b1;
    #1;
    check_eq("rst_tready", 64'(s_axis_tready), 64'd0);
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst_occ", 64'(occupancy), 64'd0);
    check_eq("rst_pkt", 64'(pkt_count), 64'd0);
    check_eq("rst_ovf", 64'(oversize), 64'd0);
    q.delete();
    m_ct  = 1'b0;
    m_ovf = 1'b0;
    m_rdy = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    bit pushed;
    aclk = 1'b0;
    areset = 1'b0;
    s_axis_tdata = '0;
    s_axis_tstrb = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    checks = 0;
    errors = 0;
    #1;
    do_reset();
    drain(1, 0);
    check_eq("post_rst_tready", 64'(s_axis_tready), 64'd1);

    // Basic packet: 1..8, held until complete, then streamed back-to-back.
    send_beats(8, 1'b1, 100, 100, 1'b0);
    check_eq("basic_pkt", 64'(pkt_count), 64'd1);
    check_eq("basic_tvalid", 64'(m_axis_tvalid), 64'd1);
    check_eq("basic_head", 64'(m_axis_tdata), 64'd1);
    drain(12, 100);
    check_eq("basic_empty_pkt", 64'(pkt_count), 64'd0);

    // Store hold: 3 beats wait, tlast on beat 4 releases the packet.
    send_beats(3, 1'b0, 100, 100, 1'b0);
    check_eq("hold_occ", 64'(occupancy), 64'd3);
    check_eq("hold_tvalid", 64'(m_axis_tvalid), 64'd0);
    step(1'b1, 32'h0000_0004, 4'hF, 1'b1, 1'b1, pushed);
    check_eq("hold_release", 64'(m_axis_tvalid), 64'd1);
    drain(8, 100);

    // Oversize: 20-beat packet forces cut-through.
    send_beats(20, 1'b1, 100, 100, 1'b0);
    drain(24, 100);
    check_eq("ovf_flag", 64'(oversize), 64'd1);
    check_eq("ovf_pkt", 64'(pkt_count), 64'd0);
    check_eq("ovf_occ", 64'(occupancy), 64'd0);
    send_beats(3, 1'b0, 100, 100, 1'b1);
    check_eq("ovf_back_to_store", 64'(m_axis_tvalid), 64'd0);
    step(1'b1, 32'hA5A5_0001, 4'h3, 1'b1, 1'b0, pushed);
    drain(10, 100);

    // Backpressure and pointer wrap: 3 packets of 6 random beats.
    for (int p = 0; p < 3; p++) send_beats(6, 1'b1, 50, 80, 1'b1);
    drain(40, 50);

    // Simultaneous tlast write and tlast pop.
    send_beats(2, 1'b1, 0, 100, 1'b1);
    send_beats(2, 1'b0, 0, 100, 1'b1);
    step(1'b1, 32'h1111_2222, 4'hF, 1'b0, 1'b1, pushed);
    step(1'b1, 32'h3333_4444, 4'hF, 1'b1, 1'b1, pushed);
    check_eq("simul_pkt", 64'(pkt_count), 64'd1);
    check_eq("simul_occ", 64'(occupancy), 64'd4);
    drain(10, 100);

    // Mid-packet reset, then a clean packet.
    send_beats(5, 1'b0, 0, 100, 1'b1);
    do_reset();
    drain(1, 0);
    send_beats(8, 1'b1, 100, 100, 1'b1);
    drain(12, 100);

    // Random traffic mixing packet lengths, including oversize ones.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 70), DW'($urandom), SW'($urandom),
           ($urandom_range(i % 200 < 100 ? 5 : 30) == 0),
           ($urandom_range(99) < 60), pushed);
    end
    drain(40, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, minimum 4.
REQ-003 SHALL have port aclk, input, 1, single clock; all logic is on the rising edge.
REQ-004 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port s_axis_tdata, input, DATA_WIDTH, upstream data from the mmtostream output stream.
REQ-006 SHALL have port s_axis_tstrb, input, DATA_WIDTH/8, byte qualifiers, stored with the data.
REQ-007 SHALL have port s_axis_tlast, input, 1, end-of-packet marker.
REQ-008 SHALL have port s_axis_tvalid, input, 1, upstream valid.
REQ-009 SHALL have port s_axis_tready, output, 1, FIFO accepts a word.
REQ-010 SHALL have ports m_axis_tdata, m_axis_tstrb and m_axis_tlast, outputs with the same widths as the s_axis ports, downstream beat.
REQ-011 SHALL have port m_axis_tvalid, output, 1, downstream valid.
REQ-012 SHALL have port m_axis_tready, input, 1, downstream ready.
REQ-013 SHALL have port occupancy, output, clog2(DEPTH)+1, words stored.
REQ-014 SHALL have port pkt_count, output, clog2(DEPTH)+1, complete packets stored.
REQ-015 SHALL have port oversize, output, 1, sticky flag for a packet longer than DEPTH.

Function
REQ-016 SHALL write one entry (data, strb, last) when s_axis_tvalid && s_axis_tready.
REQ-017 SHALL drive s_axis_tready = (occupancy != DEPTH), combinationally from registered state.
REQ-018 SHALL pop one entry when m_axis_tvalid && m_axis_tready.
REQ-019 SHALL present the head entry combinationally on m_axis_*; read latency from write to visible head is 1 cycle.
REQ-020 SHALL drive m_axis_tvalid only when occupancy != 0 and at least one of the following holds: pkt_count != 0, or FSM state is CUT_THROUGH.
REQ-021 SHALL use a two-state FSM:
- STORE (reset state) holds the packet until complete.
- CUT_THROUGH releases an oversize packet.
REQ-022 SHALL transition STORE->CUT_THROUGH when occupancy == DEPTH and pkt_count == 0, and SHALL set oversize in the same cycle.
REQ-023 SHALL transition CUT_THROUGH->STORE on the cycle a popped entry has tlast=1.
REQ-024 SHALL increment pkt_count on a write with tlast=1 and decrement it on a pop with tlast=1; when both occur in the same cycle, pkt_count is unchanged.
REQ-025 SHALL NOT decrement pkt_count when a tlast pop occurs in CUT_THROUGH for a packet that was never counted as complete.
- A per-state tracking bit records whether that tlast was counted.
REQ-026 SHALL, on a simultaneous push and pop, leave occupancy unchanged; a push at full is impossible because tready=0.
REQ-027 SHALL use wr_ptr and rd_ptr of clog2(DEPTH) bits that wrap modulo DEPTH, and SHALL track full versus empty with occupancy.
REQ-028 SHALL hold m_axis_tdata, m_axis_tstrb and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-029 SHALL clear oversize only by reset.
REQ-030 SHALL NOT let s_axis_tready depend combinationally on m_axis_tready.

Reset
REQ-031 SHALL, when areset=1, asynchronously clear wr_ptr, rd_ptr, occupancy, pkt_count and oversize, and set the FSM to STORE.
REQ-032 SHALL drive m_axis_tvalid=0 and s_axis_tready=0 while areset=1, and SHALL drive s_axis_tready=1 on the first clock edge after release.
REQ-033 SHALL discard all stored data, including partial packets, when reset is asserted mid-packet.
REQ-034 SHALL NOT reset storage array contents.

Verification
REQ-035 SHALL cover basic packet: write 8 beats 0x1..0x8, tlast on beat 8, m_axis_tready=1 -> m_axis_tvalid stays 0 until the cycle after beat 8, then 8 beats 0x1..0x8 back-to-back, tlast on 0x8, pkt_count 1->0.
REQ-036 SHALL cover store hold: 3 beats without tlast -> m_axis_tvalid=0 and occupancy=3; beat 4 with tlast -> m_axis_tvalid=1 on the next cycle.
REQ-037 SHALL cover oversize: 20 beats without tlast, DEPTH=16 -> s_axis_tready=0 at occupancy 16, oversize=1, CUT_THROUGH, drain proceeds; beat 20 tlast pop -> STORE, pkt_count=0, oversize stays 1.
REQ-038 SHALL cover backpressure and wrap: 3 packets of 6 beats with random m_axis_tready -> output data identical and in order, pointers wrap, no beat lost or duplicated, m_axis_* stable while stalled.
REQ-039 SHALL cover simultaneous last: a tlast write and a tlast pop in the same cycle -> pkt_count unchanged and occupancy unchanged.
REQ-040 SHALL cover mid-packet reset: areset pulsed after 5 of 8 beats -> outputs cleared immediately, occupancy=0, pkt_count=0, oversize=0, and a following packet passes correctly.
